// File: rtl/writeback_regfile.sv
// writeback_regfile: W-stage commit into the 15-entry Y86 register file.
// Holds the architectural run/halt/error status. Once that status leaves RUN,
// every later commit is blocked until reset.
// Optional feature macro: PERF_CNT_EN adds the retired-instruction and
// RUN-cycle counters. Without it, retired_o and cycles_o are tied to zero.
module writeback_regfile #(
   parameter logic [63:0] RSP_RESET = 64'h0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [2:0]  W_stat_i,
   input  logic [3:0]  W_icode_i,
   input  logic [63:0] W_valE_i,
   input  logic [63:0] W_valM_i,
   input  logic [3:0]  W_dstE_i,
   input  logic [3:0]  W_dstM_i,
   input  logic [3:0]  d_srcA_i,
   input  logic [3:0]  d_srcB_i,
   output logic [63:0] d_rvalA_o,
   output logic [63:0] d_rvalB_o,
   input  logic [3:0]  dbg_addr_i,
   output logic [63:0] dbg_data_o,
   output logic [2:0]  cpu_stat_o,
   output logic        halted_o,
   output logic [63:0] retired_o,
   output logic [63:0] cycles_o
);

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;
   localparam logic [3:0] RNONE    = 4'hF;
   localparam logic [3:0] INOP     = 4'h1;
   localparam int         NUM_REGS = 15;
   localparam int         RSP_IDX  = 4;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_HALT,
      ST_ERR
   } state_t;

   state_t      state;
   logic        commit_en;
   logic [63:0] regs [NUM_REGS];

   // Only a good instruction retiring while the machine still runs may commit.
   assign commit_en = (state == ST_RUN) && (W_stat_i == STAT_AOK);

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      // Per-entry write. When dstE and dstM name the same register, valM wins.
      always_ff @(posedge clk_i or posedge rst_i) begin
         // NOTE: the register file has architectural reset values (%rsp in
         // particular), so every entry is reset here. It is not left as an
         // uninitialised RAM.
         if (rst_i) begin
            regs[g] <= (g == RSP_IDX) ? RSP_RESET : 64'h0;
         end else if (commit_en && (W_dstM_i == 4'(g))) begin
            regs[g] <= W_valM_i;
         end else if (commit_en && (W_dstE_i == 4'(g))) begin
            regs[g] <= W_valE_i;
         end
      end
   end

   // Combinational read ports. RNONE reads as zero, and there is no write bypass.
   always_comb begin
      d_rvalA_o  = (d_srcA_i   == RNONE) ? 64'h0 : regs[d_srcA_i];
      d_rvalB_o  = (d_srcB_i   == RNONE) ? 64'h0 : regs[d_srcB_i];
      dbg_data_o = (dbg_addr_i == RNONE) ? 64'h0 : regs[dbg_addr_i];
   end

   // Architectural status FSM. HALT and ERR are terminal until reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= ST_RUN;
         cpu_stat_o <= STAT_AOK;
         halted_o   <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (W_stat_i == STAT_HLT) begin
                  state      <= ST_HALT;
                  cpu_stat_o <= STAT_HLT;
                  halted_o   <= 1'b1;
               end else if ((W_stat_i == STAT_ADR) || (W_stat_i == STAT_INS)) begin
                  state      <= ST_ERR;
                  cpu_stat_o <= W_stat_i;
                  halted_o   <= 1'b1;
               end
            end
            default: begin
               state      <= state;
               cpu_stat_o <= cpu_stat_o;
               halted_o   <= 1'b1;
            end
         endcase
      end
   end

`ifdef PERF_CNT_EN
   // Performance counters. Both freeze once the machine leaves RUN.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         retired_o <= 64'h0;
         cycles_o  <= 64'h0;
      end else if (state == ST_RUN) begin
         cycles_o <= cycles_o + 64'd1;
         if (commit_en && (W_icode_i != INOP)) begin
            retired_o <= retired_o + 64'd1;
         end
      end
   end
`else
   logic unused_icode;

   assign unused_icode = ^W_icode_i;
   assign retired_o    = 64'h0;
   assign cycles_o     = 64'h0;
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: directed scenarios plus randomized traffic.
// Every result is compared against an architectural model of the register
// file, the status and the counters.
module tb_writeback_regfile;

   localparam logic [63:0] RSP_INIT = 64'h100;
   localparam logic [3:0]  RNONE    = 4'hF;
   localparam logic [3:0]  INOP     = 4'h1;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [2:0]  W_stat_i;
   logic [3:0]  W_icode_i;
   logic [63:0] W_valE_i;
   logic [63:0] W_valM_i;
   logic [3:0]  W_dstE_i;
   logic [3:0]  W_dstM_i;
   logic [3:0]  d_srcA_i;
   logic [3:0]  d_srcB_i;
   logic [63:0] d_rvalA_o;
   logic [63:0] d_rvalB_o;
   logic [3:0]  dbg_addr_i;
   logic [63:0] dbg_data_o;
   logic [2:0]  cpu_stat_o;
   logic        halted_o;
   logic [63:0] retired_o;
   logic [63:0] cycles_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Architectural model: 16 slots, where slot 15 (RNONE) always stays zero.
   logic [63:0] m_regs [16];
   logic        m_frozen;
   logic [2:0]  m_stat;
   logic [63:0] m_retired;
   logic [63:0] m_cycles;

   writeback_regfile #(.RSP_RESET(RSP_INIT)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .W_stat_i(W_stat_i), .W_icode_i(W_icode_i),
      .W_valE_i(W_valE_i), .W_valM_i(W_valM_i),
      .W_dstE_i(W_dstE_i), .W_dstM_i(W_dstM_i),
      .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
      .d_rvalA_o(d_rvalA_o), .d_rvalB_o(d_rvalB_o),
      .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o),
      .cpu_stat_o(cpu_stat_o), .halted_o(halted_o),
      .retired_o(retired_o), .cycles_o(cycles_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_retired();
`ifdef PERF_CNT_EN
      return m_retired;
`else
      return 64'h0;
`endif
   endfunction

   function automatic logic [63:0] exp_cycles();
`ifdef PERF_CNT_EN
      return m_cycles;
`else
      return 64'h0;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 64'h0;
      m_regs[4] = RSP_INIT;
      m_frozen  = 1'b0;
      m_stat    = 3'd1;
      m_retired = 64'h0;
      m_cycles  = 64'h0;
   endtask

   task automatic check_status(input string tag);
      check({tag, ".stat"},    {61'h0, cpu_stat_o}, {61'h0, m_stat});
      check({tag, ".halted"},  {63'h0, halted_o},   {63'h0, m_frozen});
      check({tag, ".retired"}, retired_o,           exp_retired());
      check({tag, ".cycles"},  cycles_o,            exp_cycles());
   endtask

   // Point all three read ports at random addresses and compare them.
   task automatic check_reads(input string tag);
      d_srcA_i   = 4'($urandom_range(0, 15));
      d_srcB_i   = 4'($urandom_range(0, 15));
      dbg_addr_i = 4'($urandom_range(0, 15));
      #1;
      check({tag, ".rvalA"}, d_rvalA_o,  m_regs[d_srcA_i]);
      check({tag, ".rvalB"}, d_rvalB_o,  m_regs[d_srcB_i]);
      check({tag, ".dbg"},   dbg_data_o, m_regs[dbg_addr_i]);
   endtask

   // Read every address, including RNONE, through the debug port.
   task automatic sweep(input string tag);
      for (int a = 0; a < 16; a++) begin
         dbg_addr_i = 4'(a);
         #1;
         check($sformatf("%s.r%0d", tag, a), dbg_data_o, m_regs[a]);
      end
   endtask

   // Present one W-stage instruction, clock it, update the model, check status.
   task automatic run_cycle(input logic [2:0] stat, input logic [3:0] icode,
                            input logic [63:0] vale, input logic [63:0] valm,
                            input logic [3:0] dste, input logic [3:0] dstm);
      W_stat_i  = stat;
      W_icode_i = icode;
      W_valE_i  = vale;
      W_valM_i  = valm;
      W_dstE_i  = dste;
      W_dstM_i  = dstm;
      @(posedge clk_i);
      if (!m_frozen) begin
         if (stat == 3'd1) begin
            if (dste != RNONE) m_regs[dste] = vale;
            if (dstm != RNONE) m_regs[dstm] = valm;
            if (icode != INOP) m_retired++;
         end
         m_cycles++;
         if (stat == 3'd2) begin
            m_frozen = 1'b1;
            m_stat   = 3'd2;
         end else if (stat == 3'd3 || stat == 3'd4) begin
            m_frozen = 1'b1;
            m_stat   = stat;
         end
      end
      #1;
      check_status("cyc");
   endtask

   // Assert reset between edges and check that it clears state at once.
   // Hold it across an edge carrying a valid write, which must be discarded.
   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      model_reset();
      check_status("rst_async");
      dbg_addr_i = 4'd4;
      #1;
      check("rst_async.rsp", dbg_data_o, RSP_INIT);
      W_stat_i  = 3'd1;
      W_icode_i = 4'h6;
      W_dstE_i  = 4'd5;
      W_valE_i  = 64'hDEAD;
      W_dstM_i  = RNONE;
      @(posedge clk_i);
      #1;
      dbg_addr_i = 4'd5;
      #1;
      check("rst_discard.r5", dbg_data_o, 64'h0);
      check_status("rst_hold");
      rst_i    = 1'b0;
      W_stat_i = 3'd0;
   endtask

   initial begin
      rst_i = 1'b1;
      W_stat_i = 3'd0; W_icode_i = INOP; W_valE_i = '0; W_valM_i = '0;
      W_dstE_i = RNONE; W_dstM_i = RNONE;
      d_srcA_i = RNONE; d_srcB_i = RNONE; dbg_addr_i = 4'd0;
      model_reset();
      #12;
      check_status("reset");
      sweep("reset");
      #1;
      check("reset.srcA_none", d_rvalA_o, 64'h0);
      rst_i = 1'b0;

      // Single dstE write to register 3.
      run_cycle(3'd1, 4'h6, 64'hA5, 64'h0, 4'd3, RNONE);
      dbg_addr_i = 4'd3;
      #1;
      check("wrE.r3", dbg_data_o, 64'hA5);
      sweep("wrE");

      // Same destination on both ports: valM must win.
      run_cycle(3'd1, 4'hB, 64'h108, 64'h55, 4'd4, 4'd4);
      dbg_addr_i = 4'd4;
      #1;
      check("popq.r4", dbg_data_o, 64'h55);

      // A bubble must neither write nor change the status.
      run_cycle(3'd0, INOP, 64'hFF, 64'h0, 4'd2, RNONE);
      dbg_addr_i = 4'd2;
      #1;
      check("bubble.r2", dbg_data_o, 64'h0);
      check("bubble.stat", {61'h0, cpu_stat_o}, 64'd1);

      // An address error freezes the machine, and later commits are ignored.
      run_cycle(3'd3, 4'h6, 64'h7, 64'h0, 4'd1, RNONE);
      check("adr.stat", {61'h0, cpu_stat_o}, 64'd3);
      check("adr.halted", {63'h0, halted_o}, 64'd1);
      run_cycle(3'd1, 4'h6, 64'h99, 64'h0, 4'd1, RNONE);
      dbg_addr_i = 4'd1;
      #1;
      check("frozen.r1", dbg_data_o, 64'h0);
      sweep("frozen");

      // Counter scenario: 5 real retires, 2 INOPs, then a halt.
      do_reset();
      for (int i = 0; i < 5; i++)
         run_cycle(3'd1, 4'h6, 64'(i + 10), 64'h0, 4'(i), RNONE);
      run_cycle(3'd1, INOP, 64'h0, 64'h0, RNONE, RNONE);
      run_cycle(3'd1, INOP, 64'h0, 64'h0, RNONE, RNONE);
      run_cycle(3'd2, 4'h0, 64'h0, 64'h0, RNONE, RNONE);
`ifdef PERF_CNT_EN
      check("perf.retired", retired_o, 64'd5);
      check("perf.cycles", cycles_o, 64'd8);
`endif
      check("halt.stat", {61'h0, cpu_stat_o}, 64'd2);
      for (int i = 0; i < 3; i++)
         run_cycle(3'd1, 4'h6, 64'h1, 64'h0, 4'd6, RNONE);
      sweep("halt");

      // An instruction error latches status 4.
      do_reset();
      run_cycle(3'd1, 4'h6, 64'h3, 64'h0, 4'd7, RNONE);
      run_cycle(3'd4, 4'h6, 64'h3, 64'h0, 4'd7, RNONE);
      check("ins.stat", {61'h0, cpu_stat_o}, 64'd4);

      // Reset in the middle of a run clears the counters asynchronously.
      do_reset();
      for (int i = 0; i < 3; i++)
         run_cycle(3'd1, 4'h2, 64'h5, 64'h0, 4'd8, RNONE);
      do_reset();

      // Randomized traffic with occasional faults and resets.
      for (int n = 0; n < 600; n++) begin
         int          r;
         logic [2:0]  st;
         logic [3:0]  ic;
         r  = int'($urandom_range(0, 199));
         st = (r < 20) ? 3'd0 : (r < 196) ? 3'd1 : 3'(2 + (r % 3));
         ic = ($urandom_range(0, 9) == 0) ? INOP : 4'($urandom_range(0, 11));
         run_cycle(st, ic, {$urandom, $urandom}, {$urandom, $urandom},
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         check_reads("rand");
         if ((m_frozen && $urandom_range(0, 7) == 0) || $urandom_range(0, 99) == 0)
            do_reset();
      end
      sweep("final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Write-back end of the M->W pipeline interface.
- Consumes the W-stage register outputs (stat, icode, valE, valM, dstE, dstM) and commits results into the 15-entry Y86 program register file.
- Provides the two decode-stage read ports and a debug read port.
- Latches the architectural CPU status; once a non-AOK instruction retires, the machine is frozen and all further commits are blocked.

Parameters:
RSP_RESET, 64'h0, reset value of register 4 (%rsp); all other registers reset to 0.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
W_stat_i  in  3  W-stage status: 0=BUB, 1=AOK, 2=HLT, 3=ADR, 4=INS
W_icode_i  in  4  W-stage icode (INOP for bubbles)
W_valE_i  in  64  ALU result to write to dstE
W_valM_i  in  64  memory result to write to dstM
W_dstE_i  in  4  destination for valE; RNONE (4'hF) = none
W_dstM_i  in  4  destination for valM; RNONE = none
d_srcA_i  in  4  decode read address A
d_srcB_i  in  4  decode read address B
d_rvalA_o  out  64  register[d_srcA_i], combinational
d_rvalB_o  out  64  register[d_srcB_i], combinational
dbg_addr_i  in  4  debug read address
dbg_data_o  out  64  register[dbg_addr_i], combinational
cpu_stat_o  out  3  registered architectural status
halted_o  out  1  1 when state != RUN; drives W_stall to the W pipe register
retired_o  out  64  retired-instruction count (optional feature)
cycles_o  out  64  cycles spent in RUN (optional feature)

Behaviour:
- Reset (rst_i=1, async):
  - regs[0..14] = 0, except regs[4] = RSP_RESET.
  - state = RUN, cpu_stat_o = 1 (AOK), halted_o = 0, counters = 0.
- State machine, evaluated on each rising edge:
  - RUN -> HALT when W_stat_i == 2.
  - RUN -> ERR when W_stat_i == 3 or 4.
  - HALT and ERR are terminal until reset.
- cpu_stat_o updates on the same edge as the transition:
  - RUN: AOK.
  - HALT: 2.
  - ERR: the latched W_stat_i value (3 or 4).
  - W_stat_i == 0 (bubble) never changes cpu_stat_o.
- halted_o = (state != RUN), registered.
- Commit enable = (state == RUN) && (W_stat_i == AOK).
  - Bubbles (stat 0) and faulting or halting instructions never write.
  - Latency: a write becomes visible on the read ports in the cycle after the edge. There is no internal write-to-read bypass; decode forwarding covers same-cycle W values.
- Write rules under commit enable:
  - dstE != RNONE: regs[dstE] <= valE.
  - dstM != RNONE: regs[dstM] <= valM.
  - dstE == dstM != RNONE: valM wins (popq %rsp semantics).
  - Address RNONE is never written.
- Reads: address RNONE (4'hF) returns 64'h0 on all three read ports. Addresses 0..14 return stored values.
- Reset asserted mid-run, including in HALT or ERR: immediate return to reset values; commits in the reset cycle are discarded.
- X on W_dst*_i while commit enable is 0 has no effect.

Optional Feature:
PERF_CNT_EN
- Defined:
  - retired_o increments by 1 on each edge with commit enable and W_icode_i != INOP.
  - cycles_o increments on each edge while state == RUN.
  - Both are 64-bit, wrap modulo 2^64, freeze in HALT/ERR, and clear on reset.
- Undefined: counter logic is not built; retired_o and cycles_o are tied to 64'h0.

Test Plan:
- Reset with RSP_RESET=64'h100 -> regs[4]=64'h100, others 0; cpu_stat_o=1; halted_o=0; d_rvalA_o with srcA=4'hF reads 0.
- W_stat=1, dstE=3, valE=64'hA5, dstM=F -> next cycle dbg_addr=3 reads 64'hA5; no other register changes.
- W_stat=1, dstE=4, valE=64'h108, dstM=4, valM=64'h55 -> regs[4]=64'h55.
- Bubble: W_stat=0, dstE=2, valE=64'hFF -> regs[2] unchanged; cpu_stat_o stays 1.
- W_stat=3, dstE=1, valE=7 -> regs[1] unchanged; next cycle cpu_stat_o=3 and halted_o=1. A following W_stat=1 write to reg 1 is ignored.
- With PERF_CNT_EN: 5 AOK non-INOP retires plus 2 INOP, then W_stat=2 -> retired_o=5 and cycles_o freeze; cpu_stat_o=2. Asserting rst_i mid-sequence clears both asynchronously.
